// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: scans two N-bit operands MSB-first,
// K bits per clock, stopping as soon as a chunk decides the result.
module seq_mag_comp #(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         g,
    output logic         e,
    output logic         s
);

    localparam int C  = N / K;
    localparam int IW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  ra, ra_n;
    logic [N-1:0]  rb, rb_n;
    logic [IW-1:0] idx, idx_n;
    logic          g_n, e_n, s_n;
    logic [K-1:0]  ca, cb;
    logic [N-1:0]  msk;

    // Current chunk; an unsigned chunk compare equals "first differing bit decides".
    always_comb begin
        ca  = K'(ra >> (K * int'(idx)));
        cb  = K'(rb >> (K * int'(idx)));
        msk = {is_signed, {(N-1){1'b0}}};
    end

    // Next-state, operand capture and flag update.
    always_comb begin
        state_n = state;
        ra_n    = ra;
        rb_n    = rb;
        idx_n   = idx;
        g_n     = g;
        e_n     = e;
        s_n     = s;
        unique case (state)
            IDLE: begin
                if (start) begin
                    // Offset-binary mapping turns a signed compare into unsigned.
                    ra_n    = a ^ msk;
                    rb_n    = b ^ msk;
                    idx_n   = IW'(C - 1);
                    state_n = RUN;
                end
            end
            RUN: begin
                if ((ca != cb) || (idx == '0)) begin
                    g_n     = (ca > cb);
                    e_n     = (ca == cb);
                    s_n     = (ca < cb);
                    state_n = DONE;
                end else begin
                    idx_n = idx - 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and flag registers; reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            idx   <= '0;
            g     <= 1'b0;
            e     <= 1'b0;
            s     <= 1'b0;
        end else begin
            state <= state_n;
            ra    <= ra_n;
            rb    <= rb_n;
            idx   <= idx_n;
            g     <= g_n;
            e     <= e_n;
            s     <= s_n;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp: four instances (K = 1, 2, 4, 8) share stimulus;
// expected flags and latency are queued at start and popped at done.
module tb_seq_mag_comp;

    localparam int N = 8;

    typedef struct packed {
        logic [2:0] f;
        logic [7:0] lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [3:0]   busy, done, g, e, s;

    int tests = 0;
    int fails = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    seq_mag_comp #(.N(N), .K(1)) u_k1 (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy[0]), .done(done[0]),
        .g(g[0]), .e(e[0]), .s(s[0])
    );
    seq_mag_comp #(.N(N), .K(2)) u_k2 (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy[1]), .done(done[1]),
        .g(g[1]), .e(e[1]), .s(s[1])
    );
    seq_mag_comp #(.N(N), .K(4)) u_k4 (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy[2]), .done(done[2]),
        .g(g[2]), .e(e[2]), .s(s[2])
    );
    seq_mag_comp #(.N(N), .K(8)) u_k8 (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy[3]), .done(done[3]),
        .g(g[3]), .e(e[3]), .s(s[3])
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic sg, input int k);
        exp_t r;
        logic gt, lt;
        int p;
        int j;
        p = -1;
        if (sg) begin
            gt = $signed(x) > $signed(y);
            lt = $signed(x) < $signed(y);
        end else begin
            gt = x > y;
            lt = x < y;
        end
        for (int i = 0; i < N; i++)
            if (x[i] != y[i]) p = i;
        j = (p < 0) ? N / k : (N - 1 - p) / k + 1;
        r.f = {gt, !gt && !lt, lt};
        r.lat = 8'(j);
        return r;
    endfunction

    task automatic push_all(input logic [7:0] x, input logic [7:0] y,
                            input logic sg);
        q0.push_back(model(x, y, sg, 1));
        q1.push_back(model(x, y, sg, 2));
        q2.push_back(model(x, y, sg, 4));
        q3.push_back(model(x, y, sg, 8));
    endtask

    task automatic pop(input int k, output exp_t it, output bit ok);
        ok = 1'b1;
        it = '0;
        case (k)
            0: if (q0.size() == 0) ok = 1'b0; else it = q0.pop_front();
            1: if (q1.size() == 0) ok = 1'b0; else it = q1.pop_front();
            2: if (q2.size() == 0) ok = 1'b0; else it = q2.pop_front();
            default: if (q3.size() == 0) ok = 1'b0; else it = q3.pop_front();
        endcase
    endtask

    // One operation on all instances; optionally pulses start and
    // scrambles the inputs while the slower instances are still running.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                         input logic sg, input bit disturb,
                         input string tag);
        int   bcnt[4];
        bit   seen[4];
        int   n;
        exp_t it;
        bit   ok;
        bcnt = '{default: 0};
        seen = '{default: 0};
        push_all(x, y, sg);
        a = x;
        b = y;
        is_signed = sg;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (1) begin
            if (disturb && n == 2) begin
                start = 1'b1;
                a = ~x;
                b = x;
                is_signed = ~sg;
            end else if (disturb && n == 3) begin
                start = 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                if (!seen[k]) begin
                    if (done[k]) begin
                        seen[k] = 1'b1;
                        pop(k, it, ok);
                        check({tag, "_q"}, 32'(ok), 32'd1);
                        check({tag, "_flags"}, 32'({g[k], e[k], s[k]}),
                              32'(it.f));
                        check({tag, "_onehot"},
                              32'($countones({g[k], e[k], s[k]})), 32'd1);
                        check({tag, "_busy_cycles"}, 32'(bcnt[k]),
                              32'(it.lat));
                        check({tag, "_done_cycle"}, 32'(n),
                              32'(it.lat) + 32'd1);
                        check({tag, "_busy_at_done"}, 32'(busy[k]), 32'd0);
                    end else if (busy[k]) begin
                        bcnt[k]++;
                    end
                end
            end
            if ((seen[0] && seen[1] && seen[2] && seen[3]) || n >= 12)
                break;
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            check({tag, "_finished"}, 32'(seen[k]), 32'd1);
            if (!seen[k]) pop(k, it, ok);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] x, y;
        logic       sg;

        // Reset held with start high: everything must stay quiet.
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_flags", 32'({g, e, s}), 32'd0);
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        do_op(8'hF0, 8'h0F, 1'b0, 1'b0, "f0_0f_u");
        check("f0_0f_g", 32'(g[1]), 32'd1);

        do_op(8'hA5, 8'hA5, 1'b0, 1'b0, "a5_eq");
        repeat (5) begin
            @(negedge clk);
            check("eq_hold_e", 32'(e), 32'hF);
            check("eq_hold_gs", 32'({g, s}), 32'd0);
            check("eq_hold_busy", 32'({busy, done}), 32'd0);
        end

        do_op(8'hFF, 8'h01, 1'b0, 1'b0, "ff_01_u");
        check("ff_01_u_g", 32'(g[1]), 32'd1);
        do_op(8'hFF, 8'h01, 1'b1, 1'b0, "ff_01_s");
        check("ff_01_s_s", 32'(s[1]), 32'd1);
        do_op(8'h80, 8'h7F, 1'b1, 1'b0, "80_7f_s");
        check("80_7f_s_s", 32'(s[1]), 32'd1);

        do_op(8'h04, 8'h05, 1'b0, 1'b1, "disturb");
        check("disturb_s", 32'(s[1]), 32'd1);

        // Abort an operation in its second RUN cycle.
        a = 8'h04;
        b = 8'h05;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_pre_busy", 32'(busy[1]), 32'd1);
        check("abort_pre_s", 32'(s[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_flags", 32'({g, e, s}), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_done", 32'(done), 32'd0);
            check("abort_hold_flags", 32'({g, e, s}), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'({busy, done}), 32'd0);

        for (int i = 0; i < 500; i++) begin
            x = 8'($urandom);
            case ($urandom_range(0, 3))
                0: y = x;
                1: y = x ^ (8'd1 << $urandom_range(0, 7));
                default: y = 8'($urandom);
            endcase
            sg = 1'($urandom_range(0, 1));
            do_op(x, y, sg, 1'b0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
